// File: rtl/pc_seq_pkg.sv
// Shared types for the PC sequencer: FSM state encoding and next-PC select codes.
package pc_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    REDIR,
    HALTED
  } state_t;

  localparam logic [1:0] SEL_SEQ = 2'd0;
  localparam logic [1:0] SEL_JMP = 2'd1;
  localparam logic [1:0] SEL_BR  = 2'd2;
  localparam logic [1:0] SEL_JR  = 2'd3;

endpackage

// File: rtl/pc_sel_prio.sv
// Next-PC select: a taken branch overrides the decoder, then the candidate is muxed
// (pc+4 or a word-aligned target).
module pc_sel_prio
  import pc_seq_pkg::*;
#(
  parameter int AW = 32
) (
  input  logic          inbranch,
  input  logic [1:0]    pcmuxdecoder,
  input  logic [AW-1:0] pc,
  input  logic [AW-1:0] branch_target,
  input  logic [AW-1:0] jump_target,
  input  logic [AW-1:0] jr_target,
  output logic [1:0]    sel,
  output logic [AW-1:0] next_pc
);

  logic [AW-1:0] raw_target;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    raw_target = jr_target;
    sel        = inbranch ? SEL_BR : pcmuxdecoder;
    case (sel)
      SEL_JMP: raw_target = jump_target;
      SEL_BR:  raw_target = branch_target;
      default: raw_target = jr_target;
    endcase
    next_pc = (sel == SEL_SEQ) ? pc + AW'(4) : {raw_target[AW-1:2], 2'b00};
  end

endmodule

// File: rtl/pc_seq_ctrl.sv
// PC sequencing FSM: fetch handshake, stall/halt handling and redirect.
// Build option PC_DELAY_SLOT_EN replaces the flush/REDIR redirect with a branch delay slot.
module pc_seq_ctrl
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          AW       = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inbranch,
  input  logic [1:0]    pcmuxdecoder,
  input  logic [AW-1:0] branch_target,
  input  logic [AW-1:0] jump_target,
  input  logic [AW-1:0] jr_target,
  input  logic          stall,
  input  logic          halt,
  input  logic          imem_ready,
  output logic          imem_req,
  output logic [AW-1:0] pc,
  output logic [1:0]    pcmuxtoimem,
  output logic          instr_valid,
  output logic          flush
);

  state_t        state, state_nxt;
  logic [AW-1:0] pc_nxt;
  logic [1:0]    pcmux_nxt;
  logic [1:0]    sel;
  logic [AW-1:0] next_pc;

  pc_sel_prio #(.AW(AW)) u_sel (
    .inbranch      (inbranch),
    .pcmuxdecoder  (pcmuxdecoder),
    .pc            (pc),
    .branch_target (branch_target),
    .jump_target   (jump_target),
    .jr_target     (jr_target),
    .sel           (sel),
    .next_pc       (next_pc)
  );

`ifdef PC_DELAY_SLOT_EN
  // Redirect target held while the delay-slot instruction is fetched.
  logic          pend_q, pend_nxt;
  logic [AW-1:0] tgt_q, tgt_nxt;
`endif

  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    pcmux_nxt   = pcmuxtoimem;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    flush       = 1'b0;
`ifdef PC_DELAY_SLOT_EN
    pend_nxt    = pend_q;
    tgt_nxt     = tgt_q;
`endif
    case (state)
      IDLE: state_nxt = FETCH;
      FETCH, WAIT: begin
        // A stall freezes everything, including data that arrives in the same cycle.
        if (!stall) begin
          imem_req = 1'b1;
          if (imem_ready) begin
            instr_valid = 1'b1;
            state_nxt   = FETCH;
            if (halt) begin
              state_nxt = HALTED;
            end else begin
              pcmux_nxt = sel;
`ifdef PC_DELAY_SLOT_EN
              if (pend_q) begin
                pc_nxt   = tgt_q;
                pend_nxt = 1'b0;
              end else if (sel != SEL_SEQ) begin
                pc_nxt   = pc + AW'(4);
                tgt_nxt  = next_pc;
                pend_nxt = 1'b1;
              end else begin
                pc_nxt = next_pc;
              end
`else
              pc_nxt = next_pc;
              if (sel != SEL_SEQ) state_nxt = REDIR;
`endif
            end
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      REDIR: begin
        flush     = 1'b1;
        state_nxt = FETCH;
      end
      HALTED: state_nxt = HALTED;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= AW'(RESET_PC);
      pcmuxtoimem <= SEL_SEQ;
`ifdef PC_DELAY_SLOT_EN
      pend_q      <= 1'b0;
      tgt_q       <= '0;
`endif
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples the
      // pre-edge values regardless of statement order.
      state       <= state_nxt;
      pc          <= pc_nxt;
      pcmuxtoimem <= pcmux_nxt;
`ifdef PC_DELAY_SLOT_EN
      pend_q      <= pend_nxt;
      tgt_q       <= tgt_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Bench for pc_seq_ctrl: directed scenarios then random traffic, checked against a
// transaction-level model of the sequencing rules (honours PC_DELAY_SLOT_EN).
module tb_pc_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        inbranch = 1'b0, stall = 1'b0, halt = 1'b0, imem_ready = 1'b0;
  logic [1:0]  pcmuxdecoder = 2'd0;
  logic [31:0] branch_target = '0, jump_target = '0, jr_target = '0;
  logic        imem_req, instr_valid, flush;
  logic [31:0] pc;
  logic [1:0]  pcmuxtoimem;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: fetch address, last select, and which phase the sequencer is in.
  bit        m_started, m_redir, m_halted, m_pending;
  bit [31:0] m_pc, m_tgt;
  bit [1:0]  m_sel;

  pc_seq_ctrl #(.RESET_PC(32'h0000_0000), .AW(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .inbranch      (inbranch),
    .pcmuxdecoder  (pcmuxdecoder),
    .branch_target (branch_target),
    .jump_target   (jump_target),
    .jr_target     (jr_target),
    .stall         (stall),
    .halt          (halt),
    .imem_ready    (imem_ready),
    .imem_req      (imem_req),
    .pc            (pc),
    .pcmuxtoimem   (pcmuxtoimem),
    .instr_valid   (instr_valid),
    .flush         (flush)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit [31:0] plus4(input bit [31:0] a);
    return 32'((64'(a) + 64'd4) % 64'h1_0000_0000);
  endfunction

  function automatic bit [31:0] align(input bit [31:0] t);
    return t - (t % 32'd4);
  endfunction

  function automatic bit fetching();
    return m_started && !m_redir && !m_halted;
  endfunction

  task automatic model_reset();
    m_started = 0; m_redir = 0; m_halted = 0; m_pending = 0;
    m_pc = 32'h0; m_tgt = 32'h0; m_sel = 2'd0;
  endtask

  task automatic check_outputs(input string tag);
    bit e_req, e_valid;
    e_req   = fetching() && !stall;
    e_valid = e_req && imem_ready;
    chk({tag, ".imem_req"},    32'(imem_req),    32'(e_req));
    chk({tag, ".instr_valid"}, 32'(instr_valid), 32'(e_valid));
    chk({tag, ".flush"},       32'(flush),       32'(m_redir));
    chk({tag, ".pc"},          pc,               m_pc);
    chk({tag, ".pcmux"},       32'(pcmuxtoimem), 32'(m_sel));
  endtask

  // One clock: check settled outputs, advance the model across the edge, return at edge+1.
  task automatic cyc();
    bit        acc;
    bit [1:0]  s;
    bit [31:0] t;
    #3;
    check_outputs("cyc");
    acc = fetching() && !stall && imem_ready;
    if (!m_started) m_started = 1;
    else if (m_redir) m_redir = 0;
    else if (acc) begin
      if (halt) m_halted = 1;
      else begin
        s = inbranch ? 2'd2 : pcmuxdecoder;
        t = (s == 2'd1) ? jump_target : (s == 2'd2) ? branch_target : jr_target;
        m_sel = s;
`ifdef PC_DELAY_SLOT_EN
        if (m_pending) begin
          m_pc = m_tgt; m_pending = 0;
        end else begin
          if (s != 2'd0) begin m_tgt = align(t); m_pending = 1; end
          m_pc = plus4(m_pc);
        end
`else
        if (s == 2'd0) m_pc = plus4(m_pc);
        else begin m_pc = align(t); m_redir = 1; end
`endif
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset asserted between edges; outputs must clear before any clock.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic run_until(input bit [31:0] a, input int budget);
    int n = 0;
    while (!(fetching() && m_pc == a) && n < budget) begin
      cyc();
      n++;
    end
    if (!(fetching() && m_pc == a)) chk("run_until_timeout", pc, a);
  endtask

  initial begin
    #1;
    do_reset();
    imem_ready = 1'b1;

    // Sequential fetch with a 3-cycle memory wait at 0x8.
    cyc();
    chk("seq_pc0", pc, 32'h0);
    cyc();
    chk("seq_pc4", pc, 32'h4);
    cyc();
    chk("seq_pc8", pc, 32'h8);
    imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("wait_pc_held", pc, 32'h8);
    end
    imem_ready = 1'b1;
    #3;
    chk("wait_valid", 32'(instr_valid), 32'd1);
    cyc();
    chk("seq_pcC", pc, 32'hC);
    cyc();
    chk("seq_pc10", pc, 32'h10);

`ifndef PC_DELAY_SLOT_EN
    // Branch overrides the decoder's jump: flush, one REDIR bubble, then 0x40.
    inbranch = 1'b1; pcmuxdecoder = 2'd1; branch_target = 32'h40; jump_target = 32'h99;
    cyc();
    inbranch = 1'b0; pcmuxdecoder = 2'd0;
    chk("br_pcmux", 32'(pcmuxtoimem), 32'd2);
    chk("br_flush", 32'(flush), 32'd1);
    chk("br_redir_req", 32'(imem_req), 32'd0);
    chk("br_pc", pc, 32'h40);
    cyc();
    chk("br_refetch_req", 32'(imem_req), 32'd1);
    cyc();
    chk("br_next", pc, 32'h44);
    // Reset during REDIR abandons the redirect.
    pcmuxdecoder = 2'd3; jr_target = 32'h200;
    cyc();
    pcmuxdecoder = 2'd0;
    do_reset();
    cyc();
    cyc();
    chk("redir_reset_pc", pc, 32'h4);
`else
    // Delay slot: jump at 0x10 fetches 0x14 then 0x80 with no flush.
    pcmuxdecoder = 2'd1; jump_target = 32'h80;
    cyc();
    pcmuxdecoder = 2'd0;
    chk("ds_flush", 32'(flush), 32'd0);
    chk("ds_slot_pc", pc, 32'h14);
    cyc();
    chk("ds_flush2", 32'(flush), 32'd0);
    chk("ds_tgt_pc", pc, 32'h80);
    cyc();
    chk("ds_next", pc, 32'h84);
    // Reset with a target pending clears it.
    pcmuxdecoder = 2'd1; jump_target = 32'h300;
    cyc();
    pcmuxdecoder = 2'd0; imem_ready = 1'b0;
    cyc();
    do_reset();
    imem_ready = 1'b1;
    cyc();
    cyc();
    chk("ds_reset_pc", pc, 32'h4);
`endif

    // Stall coincident with imem_ready at 0x20: no acceptance, refetch after stall.
    run_until(32'h20, 40);
    stall = 1'b1;
    #3;
    chk("stall_valid", 32'(instr_valid), 32'd0);
    chk("stall_req", 32'(imem_req), 32'd0);
    cyc();
    cyc();
    chk("stall_pc", pc, 32'h20);
    stall = 1'b0;
    #3;
    chk("unstall_valid", 32'(instr_valid), 32'd1);
    cyc();
    chk("unstall_pc", pc, 32'h24);

    // Wrap at the top of the address space, then jr with misaligned target.
    pcmuxdecoder = 2'd3; jr_target = 32'hFFFF_FFFF;
    cyc();
    pcmuxdecoder = 2'd0;
    run_until(32'hFFFF_FFFC, 10);
    chk("wrap_at", pc, 32'hFFFF_FFFC);
    cyc();
    chk("wrap_pc", pc, 32'h0);
    pcmuxdecoder = 2'd3; jr_target = 32'h103;
    cyc();
    pcmuxdecoder = 2'd0;
    run_until(32'h100, 10);
    chk("jr_align", pc, 32'h100);

    // Halt on accepted fetch: frozen until reset.
    halt = 1'b1;
    cyc();
    halt = 1'b0;
    for (int i = 0; i < 4; i++) cyc();
    chk("halt_pc", pc, 32'h100);
    chk("halt_req", 32'(imem_req), 32'd0);
    do_reset();

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      stall         = ($urandom_range(0, 4) == 0);
      imem_ready    = ($urandom_range(0, 9) < 7);
      inbranch      = ($urandom_range(0, 6) == 0);
      pcmuxdecoder  = 2'($urandom_range(0, 3));
      halt          = ($urandom_range(0, 59) == 0);
      branch_target = $urandom;
      jump_target   = $urandom;
      jr_target     = $urandom;
      if ((m_halted && $urandom_range(0, 3) == 0) || $urandom_range(0, 99) == 0) do_reset();
      else cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pc_seq_ctrl.md
PC_SEQ_CTRL -- requirements
Module: pc_seq_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter AW, default 32, PC and target width.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 inbranch  in  1  branch-taken flag from the comparator; overrides the decoder select.
REQ-006 pcmuxdecoder  in  2  decoder next-PC select: 0 seq, 1 jump, 2 branch, 3 jr.
REQ-007 branch_target, jump_target, jr_target  in  AW each  candidate next-PC values.
REQ-008 stall  in  1  hazard stall; freezes sequencing.
REQ-009 halt  in  1  halt instruction decoded in the accepted fetch.
REQ-010 imem_ready  in  1  instruction memory returns data this cycle.
REQ-011 imem_req  out  1  fetch request at address pc.
REQ-012 pc  out  AW  current fetch address.
REQ-013 pcmuxtoimem  out  2  select applied at the last accepted fetch.
REQ-014 instr_valid  out  1  one-cycle pulse; fetched instruction accepted.
REQ-015 flush  out  1  one-cycle pulse; discard the younger in-flight instruction.

Function
REQ-016 FSM states IDLE, FETCH, WAIT, REDIR, HALTED; IDLE moves to FETCH one cycle after reset release.
REQ-017 Effective select = 2 when inbranch=1, else pcmuxdecoder.
REQ-018 FETCH: imem_req=1; imem_ready=1 -> instr_valid=1 and pc update; imem_ready=0 -> WAIT.
REQ-019 WAIT: imem_req=1 and pc held until imem_ready=1; then instr_valid=1, pc update, return to FETCH.
REQ-020 pc update by select: 0 pc+4, 1 jump_target, 2 branch_target, 3 jr_target; pcmuxtoimem registers the select.
REQ-021 pc+4 wraps modulo 2^AW: 0xFFFF_FFFC -> 0x0000_0000.
REQ-022 Target bits [1:0] forced to 0 on load.
REQ-023 Non-zero select: flush=1 for one cycle; REDIR for one cycle with imem_req=0; then FETCH at the new pc.
REQ-024 stall=1 in FETCH/WAIT: imem_req=0, instr_valid=0, pc and state frozen.
REQ-025 stall and imem_ready both high: stall wins, data discarded, fetch reissued after stall drops.
REQ-026 halt=1 on an accepted fetch: HALTED, imem_req=0, pc frozen; exit only by reset.
REQ-027 inbranch/pcmuxdecoder/halt sampled only in the instr_valid cycle.

Reset
REQ-028 rst_n low: state IDLE, pc=RESET_PC, pcmuxtoimem=0, imem_req=0, instr_valid=0, flush=0, immediately and asynchronously.
REQ-029 Reset mid-WAIT or mid-REDIR abandons the transaction; any pending target is cleared.

Configuration
REQ-030 Macro PC_DELAY_SLOT_EN defined: non-zero select latches the target and fetches pc+4 as a delay slot (no flush, no REDIR); pc loads the latched target after the delay-slot fetch is accepted.
REQ-031 PC_DELAY_SLOT_EN undefined: REQ-023 applies and no target latch is built.

Structure
REQ-032 Package pc_seq_pkg holds the state enum and select constants SEL_SEQ=0, SEL_JMP=1, SEL_BR=2, SEL_JR=3.
REQ-033 Sub-module pc_sel_prio: combinational branch-override priority plus target mux; the FSM stays in pc_seq_ctrl.

Verification
REQ-034 Reset release, imem_ready=1 always, select 0 -> pc 0,4,8,C; instr_valid each cycle after IDLE.
REQ-035 At pc=0x10, inbranch=1, pcmuxdecoder=1, branch_target=0x40 -> pcmuxtoimem=2, flush pulse, one REDIR cycle, next fetch at 0x40.
REQ-036 imem_ready low 3 cycles at pc=0x8 -> imem_req held, pc=0x8 throughout, single instr_valid on the 4th cycle.
REQ-037 stall and imem_ready high together at pc=0x20 -> no instr_valid; after stall drops, fetch 0x20 again.
REQ-038 pc=0xFFFF_FFFC, select 0 -> next pc 0x0; jr_target=0x103 with select 3 -> pc 0x100.
REQ-039 PC_DELAY_SLOT_EN, jump at pc=0x10 to 0x80 -> fetches 0x14 then 0x80, flush never asserted; halt=1 -> HALTED until rst_n low.
